// File: rtl/vga_mode_ctrl.sv
// Run-time video mode controller: shadow timing register file for the host,
// validated commit, and frame-aligned swap of the active timing set with a
// fixed generator reset window around every (re)start.
module vga_mode_ctrl #(
  parameter int          PW         = 14,
  parameter logic [7:0]  RST_CYCLES = 8'd4,
  parameter logic [7:0]  DEF_HS     = 8'd96,
  parameter logic [7:0]  DEF_HBP    = 8'd48,
  parameter logic [11:0] DEF_HACT   = 12'd640,
  parameter logic [7:0]  DEF_HFP    = 8'd16,
  parameter logic [7:0]  DEF_VS     = 8'd2,
  parameter logic [7:0]  DEF_VBP    = 8'd33,
  parameter logic [11:0] DEF_VACT   = 12'd480,
  parameter logic [7:0]  DEF_VFP    = 8'd10
) (
  input  logic        in_pclk,
  input  logic        in_rstn,
  input  logic        in_enable,
  input  logic        in_cfg_wr,
  input  logic [2:0]  in_cfg_addr,
  input  logic [11:0] in_cfg_wdata,
  input  logic        in_cfg_commit,
  input  logic        in_vs,
  output logic        out_gen_rstn,
  output logic [7:0]  out_hs_w,
  output logic [7:0]  out_hbp_w,
  output logic [7:0]  out_hfp_w,
  output logic [7:0]  out_vs_w,
  output logic [7:0]  out_vbp_w,
  output logic [7:0]  out_vfp_w,
  output logic [11:0] out_hact,
  output logic [11:0] out_vact,
  output logic        out_busy,
  output logic        out_ack,
  output logic        out_err,
  output logic [15:0] out_frame_cnt
);

  typedef enum logic [1:0] {S_OFF, S_RUN, S_PEND, S_HOLD} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [11:0]   r_sh [8];
  logic [11:0]   w_sh_nxt [8];
  logic          r_vs1, r_vs2;
  logic [7:0]    r_cnt, w_cnt_nxt;
  logic          r_flag, w_flag_nxt;
  logic          r_gen_rstn, r_busy, r_ack, r_err;
  logic [15:0]   r_frame_cnt;
  logic [7:0]    r_hs, r_hbp, r_hfp, r_vs_w, r_vbp, r_vfp;
  logic [11:0]   r_hact, r_vact;
  logic          w_busy, w_wr_ok, w_fs, w_valid, w_copy, w_ack_nxt, w_err_nxt;
  logic [PW:0]   w_hsum;
  logic [12:0]   w_vsum;

  assign w_busy  = (r_state == S_PEND) || (r_state == S_HOLD);
  assign w_wr_ok = in_cfg_wr && !w_busy;
  // Falling edge of the registered vsync: fires one cycle after the pin edge.
  assign w_fs    = r_vs2 && !r_vs1;

  // Shadow view including a write landing this cycle, so a same-cycle commit validates it.
  always_comb begin
    for (int i = 0; i < 8; i++) w_sh_nxt[i] = r_sh[i];
    if (w_wr_ok) w_sh_nxt[in_cfg_addr] = in_cfg_wdata;
  end

  assign w_hsum = (PW+1)'(w_sh_nxt[0]) + (PW+1)'(w_sh_nxt[1])
                + (PW+1)'(w_sh_nxt[2]) + (PW+1)'(w_sh_nxt[3]);
  assign w_vsum = 13'(w_sh_nxt[4]) + 13'(w_sh_nxt[5])
                + 13'(w_sh_nxt[6]) + 13'(w_sh_nxt[7]);

  assign w_valid = (w_sh_nxt[0] != 12'd0) && (w_sh_nxt[2] != 12'd0)
                && (w_sh_nxt[4] != 12'd0) && (w_sh_nxt[6] != 12'd0)
                && (w_sh_nxt[0][11:8] == 4'd0) && (w_sh_nxt[1][11:8] == 4'd0)
                && (w_sh_nxt[3][11:8] == 4'd0) && (w_sh_nxt[4][11:8] == 4'd0)
                && (w_sh_nxt[5][11:8] == 4'd0) && (w_sh_nxt[7][11:8] == 4'd0)
                && (w_hsum <= (PW+1)'((2**PW) - 1))
                && (w_vsum <= 13'd4095);

  // Next-state, shadow-to-active copy, and ack/err pulse decisions.
  always_comb begin
    w_next     = r_state;
    w_copy     = 1'b0;
    w_ack_nxt  = 1'b0;
    w_err_nxt  = 1'b0;
    w_cnt_nxt  = r_cnt;
    w_flag_nxt = r_flag;
    if (w_busy && (in_cfg_wr || in_cfg_commit)) w_err_nxt = 1'b1;
    case (r_state)
      S_OFF: begin
        if (in_cfg_commit) begin
          if (w_valid) begin
            w_copy    = 1'b1;
            w_ack_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        if (in_enable) begin
          // One extra HOLD cycle on the enable path: release lands RST_CYCLES+1 after enable.
          w_next     = S_HOLD;
          w_cnt_nxt  = RST_CYCLES;
          w_flag_nxt = 1'b0;
        end
      end
      S_RUN: begin
        if (in_cfg_commit) begin
          if (w_valid) w_next = S_PEND;
          else         w_err_nxt = 1'b1;
        end
      end
      S_PEND: begin
        if (w_fs) begin
          w_copy     = 1'b1;
          w_next     = S_HOLD;
          w_cnt_nxt  = RST_CYCLES - 8'd1;
          w_flag_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (r_cnt == 8'd0) begin
          w_next     = S_RUN;
          w_ack_nxt  = r_flag;
          w_flag_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      default: w_next = S_OFF;
    endcase
    // Disable wins over everything; a pending commit is simply discarded.
    if (!in_enable && (r_state != S_OFF)) begin
      w_next     = S_OFF;
      w_copy     = 1'b0;
      w_ack_nxt  = 1'b0;
      w_err_nxt  = 1'b0;
      w_flag_nxt = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge in_pclk or negedge in_rstn) begin
    if (!in_rstn) r_state <= S_OFF;
    else          r_state <= w_next;
  end

  // Control registers: vsync sampling, hold counter, status pulses, frame counter.
  always_ff @(posedge in_pclk or negedge in_rstn) begin
    if (!in_rstn) begin
      r_vs1       <= 1'b0;
      r_vs2       <= 1'b0;
      r_cnt       <= 8'd0;
      r_flag      <= 1'b0;
      r_gen_rstn  <= 1'b0;
      r_busy      <= 1'b0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_vs1      <= in_vs;
      r_vs2      <= r_vs1;
      r_cnt      <= w_cnt_nxt;
      r_flag     <= w_flag_nxt;
      r_gen_rstn <= (w_next == S_RUN) || (w_next == S_PEND);
      r_busy     <= (w_next == S_PEND) || (w_next == S_HOLD);
      r_ack      <= w_ack_nxt;
      r_err      <= w_err_nxt;
      if (w_next == S_OFF)
        r_frame_cnt <= 16'd0;
      else if (w_fs && ((r_state == S_RUN) || (r_state == S_PEND)))
        r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  // Shadow register file and active timing set.
  always_ff @(posedge in_pclk or negedge in_rstn) begin
    if (!in_rstn) begin
      r_sh[0] <= {4'd0, DEF_HS};
      r_sh[1] <= {4'd0, DEF_HBP};
      r_sh[2] <= DEF_HACT;
      r_sh[3] <= {4'd0, DEF_HFP};
      r_sh[4] <= {4'd0, DEF_VS};
      r_sh[5] <= {4'd0, DEF_VBP};
      r_sh[6] <= DEF_VACT;
      r_sh[7] <= {4'd0, DEF_VFP};
      r_hs    <= DEF_HS;
      r_hbp   <= DEF_HBP;
      r_hact  <= DEF_HACT;
      r_hfp   <= DEF_HFP;
      r_vs_w  <= DEF_VS;
      r_vbp   <= DEF_VBP;
      r_vact  <= DEF_VACT;
      r_vfp   <= DEF_VFP;
    end else begin
      for (int i = 0; i < 8; i++) r_sh[i] <= w_sh_nxt[i];
      if (w_copy) begin
        r_hs   <= w_sh_nxt[0][7:0];
        r_hbp  <= w_sh_nxt[1][7:0];
        r_hact <= w_sh_nxt[2];
        r_hfp  <= w_sh_nxt[3][7:0];
        r_vs_w <= w_sh_nxt[4][7:0];
        r_vbp  <= w_sh_nxt[5][7:0];
        r_vact <= w_sh_nxt[6];
        r_vfp  <= w_sh_nxt[7][7:0];
      end
    end
  end

  assign out_gen_rstn  = r_gen_rstn;
  assign out_busy      = r_busy;
  assign out_ack       = r_ack;
  assign out_err       = r_err;
  assign out_frame_cnt = r_frame_cnt;
  assign out_hs_w      = r_hs;
  assign out_hbp_w     = r_hbp;
  assign out_hfp_w     = r_hfp;
  assign out_vs_w      = r_vs_w;
  assign out_vbp_w     = r_vbp;
  assign out_vfp_w     = r_vfp;
  assign out_hact      = r_hact;
  assign out_vact      = r_vact;

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Scoreboard bench for vga_mode_ctrl: stimulus queues expected ack/err pulses
// and generator-reset edges (cycle + active timing set); a monitor pops them.
module tb_vga_mode_ctrl;

  logic        in_pclk = 1'b0;
  logic        in_rstn = 1'b0;
  logic        in_enable = 1'b0;
  logic        in_cfg_wr = 1'b0;
  logic [2:0]  in_cfg_addr = 3'd0;
  logic [11:0] in_cfg_wdata = 12'd0;
  logic        in_cfg_commit = 1'b0;
  logic        in_vs = 1'b1;
  logic        out_gen_rstn, out_busy, out_ack, out_err;
  logic [7:0]  out_hs_w, out_hbp_w, out_hfp_w, out_vs_w, out_vbp_w, out_vfp_w;
  logic [11:0] out_hact, out_vact;
  logic [15:0] out_frame_cnt;
  logic [71:0] act_f;

  vga_mode_ctrl #(.PW(12), .RST_CYCLES(8'd4)) dut (
    .in_pclk(in_pclk), .in_rstn(in_rstn), .in_enable(in_enable),
    .in_cfg_wr(in_cfg_wr), .in_cfg_addr(in_cfg_addr), .in_cfg_wdata(in_cfg_wdata),
    .in_cfg_commit(in_cfg_commit), .in_vs(in_vs), .out_gen_rstn(out_gen_rstn),
    .out_hs_w(out_hs_w), .out_hbp_w(out_hbp_w), .out_hfp_w(out_hfp_w),
    .out_vs_w(out_vs_w), .out_vbp_w(out_vbp_w), .out_vfp_w(out_vfp_w),
    .out_hact(out_hact), .out_vact(out_vact), .out_busy(out_busy),
    .out_ack(out_ack), .out_err(out_err), .out_frame_cnt(out_frame_cnt)
  );

  always #5 in_pclk = ~in_pclk;

  int cyc = 0;
  always @(posedge in_pclk) cyc <= cyc + 1;

  assign act_f = {out_hs_w, out_hbp_w, out_hfp_w, out_vs_w, out_vbp_w, out_vfp_w, out_hact, out_vact};

  typedef struct { int cyc; logic [71:0] f; } ev_t;
  ev_t q_rise[$], q_fall[$], q_ack[$], q_err[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [71:0] pk(int hs, int hbp, int hact, int hfp,
                                     int vs, int vbp, int vact, int vfp);
    return {8'(hs), 8'(hbp), 8'(hfp), 8'(vs), 8'(vbp), 8'(vfp), 12'(hact), 12'(vact)};
  endfunction

  logic [71:0] M_DEF, M_800, M_EDGE;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input int c, input logic [71:0] f);
    ev_t e;
    e.cyc = c;
    e.f   = f;
    case (k)
      0: q_rise.push_back(e);
      1: q_fall.push_back(e);
      2: q_ack.push_back(e);
      default: q_err.push_back(e);
    endcase
  endtask

  task automatic take(input int k, input string nm);
    ev_t e;
    bit  have;
    have = 1'b0;
    case (k)
      0: if (q_rise.size() > 0) begin e = q_rise.pop_front(); have = 1'b1; end
      1: if (q_fall.size() > 0) begin e = q_fall.pop_front(); have = 1'b1; end
      2: if (q_ack.size()  > 0) begin e = q_ack.pop_front();  have = 1'b1; end
      default: if (q_err.size() > 0) begin e = q_err.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected event at cycle %0d actual=1 required=0", nm, cyc);
    end else begin
      chk({nm, "_cycle"}, 72'(e.cyc == cyc ? cyc : cyc), 72'(e.cyc));
      chk({nm, "_fields"}, act_f, e.f);
    end
  endtask

  // Monitor: every output event is matched against the scoreboard.
  initial begin
    logic prev_g;
    prev_g = 1'b0;
    forever begin
      @(negedge in_pclk);
      if (in_rstn) begin
        if (out_gen_rstn && !prev_g) take(0, "gen_rise");
        if (!out_gen_rstn && prev_g) take(1, "gen_fall");
        if (out_ack) take(2, "ack");
        if (out_err) take(3, "err");
      end
      prev_g = out_gen_rstn;
    end
  end

  task automatic nxt(input int n);
    repeat (n) @(negedge in_pclk);
  endtask

  task automatic wr(input int a, input int d);
    in_cfg_wr = 1'b1; in_cfg_addr = 3'(a); in_cfg_wdata = 12'(d);
    nxt(1);
    in_cfg_wr = 1'b0;
  endtask

  task automatic commit();
    in_cfg_commit = 1'b1;
    nxt(1);
    in_cfg_commit = 1'b0;
  endtask

  task automatic commit_err(input logic [71:0] f);
    push(3, cyc + 1, f);
    commit();
  endtask

  task automatic vs_frame(input int c0, input logic [71:0] f);
    // in_vs falls now; swap + reset 2 cycles later, release + ack 4 cycles after that
    push(1, c0 + 2, f);
    push(0, c0 + 6, f);
    push(2, c0 + 6, f);
    in_vs = 1'b0;
    nxt(2);
    in_vs = 1'b1;
    nxt(4);
  endtask

  initial begin
    int t;
    M_DEF  = pk(96, 48, 640, 16, 2, 33, 480, 10);
    M_800  = pk(128, 88, 800, 40, 4, 23, 600, 1);
    M_EDGE = pk(128, 88, 3839, 40, 4, 23, 600, 1);

    nxt(3);
    in_rstn = 1'b1;
    nxt(1);
    chk("rst_gen_rstn", out_gen_rstn, 0);
    chk("rst_busy", out_busy, 0);
    chk("rst_ack", out_ack, 0);
    chk("rst_err", out_err, 0);
    chk("rst_frame_cnt", out_frame_cnt, 0);
    chk("rst_fields", act_f, M_DEF);

    // enable: generator reset released RST_CYCLES+1 cycles later
    t = cyc;
    in_enable = 1'b1;
    push(0, t + 6, M_DEF);
    nxt(5);
    chk("en_hold_gen_rstn", out_gen_rstn, 0);
    chk("en_hold_busy", out_busy, 1);
    nxt(3);

    // 800x600 mode change in RUN
    wr(0, 128); wr(1, 88); wr(2, 800); wr(3, 40);
    wr(4, 4);   wr(5, 23); wr(6, 600); wr(7, 1);
    commit();
    chk("pend_busy", out_busy, 1);
    chk("pend_gen_rstn", out_gen_rstn, 1);
    chk("pend_fields_old", act_f, M_DEF);
    nxt(2);
    vs_frame(cyc, M_800);
    chk("run_busy_clear", out_busy, 0);
    chk("frame_cnt_1", out_frame_cnt, 1);
    nxt(2);

    // write + commit in one cycle: HACT=0 validated post-write
    push(3, cyc + 1, M_800);
    in_cfg_wr = 1'b1; in_cfg_addr = 3'd2; in_cfg_wdata = 12'd0; in_cfg_commit = 1'b1;
    nxt(1);
    in_cfg_wr = 1'b0; in_cfg_commit = 1'b0;
    commit_err(M_800);
    chk("hact0_busy", out_busy, 0);
    chk("hact0_gen_rstn", out_gen_rstn, 1);
    wr(2, 800);

    // range rejections
    wr(3, 'h100); commit_err(M_800); wr(3, 40);
    wr(2, 4095);  commit_err(M_800); wr(2, 800);
    wr(6, 4095);  commit_err(M_800); wr(6, 600);
    wr(4, 0);     commit_err(M_800); wr(4, 4);
    nxt(2);

    // line total exactly at 2^PW-1 is accepted; write and commit in one cycle
    in_cfg_wr = 1'b1; in_cfg_addr = 3'd2; in_cfg_wdata = 12'd3839; in_cfg_commit = 1'b1;
    nxt(1);
    in_cfg_wr = 1'b0; in_cfg_commit = 1'b0;
    chk("edge_pend_busy", out_busy, 1);
    push(3, cyc + 1, M_800);
    wr(3, 99);
    nxt(1);
    commit_err(M_800);
    nxt(1);
    vs_frame(cyc, M_EDGE);
    chk("frame_cnt_2", out_frame_cnt, 2);
    nxt(2);

    // drop enable during PEND: commit discarded
    wr(2, 800);
    commit();
    nxt(1);
    chk("drop_pend_busy", out_busy, 1);
    push(1, cyc + 1, M_EDGE);
    in_enable = 1'b0;
    nxt(1);
    chk("off_gen_rstn", out_gen_rstn, 0);
    chk("off_busy", out_busy, 0);
    chk("off_frame_cnt", out_frame_cnt, 0);
    in_vs = 1'b0; nxt(2); in_vs = 1'b1; nxt(2);
    chk("off_fields_old", act_f, M_EDGE);

    // commits while OFF apply immediately or are rejected
    push(2, cyc + 1, M_800);
    commit();
    nxt(1);
    wr(5, 'h200); commit_err(M_800); wr(5, 23);
    nxt(1);

    // re-enable and count three frames in RUN
    t = cyc;
    in_enable = 1'b1;
    push(0, t + 6, M_800);
    nxt(7);
    repeat (3) begin
      in_vs = 1'b0; nxt(2); in_vs = 1'b1; nxt(2);
    end
    nxt(2);
    chk("frame_cnt_3", out_frame_cnt, 3);

    // asynchronous reset while PEND
    wr(2, 3839);
    commit();
    nxt(1);
    chk("areset_pre_busy", out_busy, 1);
    #2 in_rstn = 1'b0;
    #1;
    chk("areset_gen_rstn", out_gen_rstn, 0);
    chk("areset_busy", out_busy, 0);
    chk("areset_ack", out_ack, 0);
    chk("areset_err", out_err, 0);
    chk("areset_frame_cnt", out_frame_cnt, 0);
    chk("areset_fields", act_f, M_DEF);
    nxt(2);
    #2 in_rstn = 1'b1;
    nxt(4);

    chk("left_rise", 72'(q_rise.size()), 0);
    chk("left_fall", 72'(q_fall.size()), 0);
    chk("left_ack", 72'(q_ack.size()), 0);
    chk("left_err", 72'(q_err.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
